// File: rtl/regfile_dump_reader.sv
// Streams register-file entries FIRST_REG..LAST_REG as indexed valid/ready beats.
// Latency: two cycles per beat minimum; optional checksum beat with REGDUMP_CHECKSUM_EN.
// Backpressure: out_* held stable while out_valid && !out_ready; readiness only matters in SEND/CSUM.
module regfile_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    generate
        if (FIRST_REG > LAST_REG || FIRST_REG < 0 || LAST_REG >= (1 << ADDR_W)) begin : g_bad_range
            $error("regfile_dump_reader: illegal FIRST_REG/LAST_REG range");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_FIN, S_CSUM} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_index_q, out_index_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    // A start coinciding with the done pulse must not launch a second dump.
    logic start_acc;
    logic hs;
    logic at_last;
    assign start_acc = start && !done_q;
    assign hs        = out_valid_q && out_ready;
    assign at_last   = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_acc) state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_d = at_last ? S_CSUM : S_LOAD;
`else
                    state_d = at_last ? S_FIN : S_LOAD;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: if (hs) state_d = S_FIN;
`endif
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    idx_d  = FIRST_IDX;
                    busy_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                out_data_d  = rf_data;
                out_index_d = idx_q;
                out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = at_last;
`endif
            end
            S_SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d       = sum_q + out_data_q;
`endif
                    if (!at_last) idx_d = idx_q + 1'b1;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            // First CSUM cycle presents the sum; later cycles wait for the handshake.
            S_CSUM: begin
                if (!out_valid_q) begin
                    out_data_d  = sum_q;
                    out_index_d = LAST_IDX;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
`endif
            S_FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign rf_addr   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 32x32 register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    logic [31:0] rf  [32];
    logic [31:0] expv[32];

    int vectors = 0;
    int miscompares = 0;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NBEATS  = 33;
    localparam int LAST_HS = 66;
`else
    localparam int NBEATS  = 32;
    localparam int LAST_HS = 64;
`endif

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic preload(input bit all_ones);
        for (int i = 0; i < 32; i++) begin
            rf[i]   = all_ones ? 32'hFFFF_FFFF : (i * 32'h1111_1111);
            expv[i] = rf[i];
        end
    endtask

    // Entered on a negedge. rmode 0: ready high; rmode 1: ready pattern 1,0,0,1.
    task automatic run_dump(input int rmode, input bit stress, input bit snap);
        int          j, beat, last_hs, first_v;
        bit          prev_stall, wrote;
        logic [31:0] pd, sum;
        logic [4:0]  pi;
        logic        pl;
        logic [3:0]  pat;
        pat = 4'b1001;
        beat = 0; last_hs = -1; first_v = -1; prev_stall = 0; wrote = 0; sum = 0;
        pd = '0; pi = '0; pl = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 1;
        while (!done && j < 400) begin
            out_ready = (rmode == 0) ? 1'b1 : pat[j % 4];
            if (stress) start = (j % 3 == 0);
            if (snap && !wrote && rf_addr == 5'd5) begin
                rf[20] = 32'hDEAD_BEEF;
                rf[3]  = 32'hCAFE_F00D;
                wrote  = 1;
            end
            check("busy_during_dump", busy, 1'b1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data",  out_data,  pd);
                check("stall_index", out_index, pi);
                check("stall_last",  out_last,  pl);
            end
            if (out_valid && first_v < 0) first_v = j;
            if (out_valid && out_ready) begin
                if (beat < 32) begin
                    check($sformatf("beat%0d_index", beat), out_index, beat[4:0]);
                    check($sformatf("beat%0d_data", beat), out_data, expv[beat]);
`ifdef REGDUMP_CHECKSUM_EN
                    check($sformatf("beat%0d_last", beat), out_last, 1'b0);
`else
                    check($sformatf("beat%0d_last", beat), out_last, beat == 31);
`endif
                    sum = sum + expv[beat];
                end else begin
                    check("csum_data",  out_data,  sum);
                    check("csum_index", out_index, 5'd31);
                    check("csum_last",  out_last,  1'b1);
                end
                beat++;
                last_hs = j;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
            @(negedge clk);
            j++;
        end
        check("done_seen", done, 1'b1);
        check("beat_count", beat, NBEATS);
        check("done_after_last_hs", j, last_hs + 2);
        check("busy_low_at_done", busy, 1'b0);
        if (rmode == 0) begin
            check("first_valid_cycle", first_v, 2);
            check("last_hs_cycle", last_hs, LAST_HS);
        end
        start = stress;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check("idle_busy", busy, 1'b0);
            check("idle_valid", out_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        int  n;
        bit  found;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        preload(0);
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_addr", rf_addr, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_in_idle_no_effect", busy, 1'b0);

        run_dump(0, 0, 0);
        preload(0);
        run_dump(1, 0, 0);

        preload(0);
        expv[20] = 32'hDEAD_BEEF;
        run_dump(0, 0, 1);

        preload(0);
        run_dump(0, 1, 0);

        // Abort mid-SEND at index 10.
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid && out_index == 5'd10) found = 1;
        end
        out_ready = 1'b0;
        check("reach_index10", found, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_last", out_last, 1'b0);
        check("arst_data", out_data, 32'h0);
        check("arst_index", out_index, 5'd0);
        check("arst_addr", rf_addr, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dump(0, 0, 0);

        preload(1);
        run_dump(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
